// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 encodings, FSM state type and default memory depth for the load/store unit.
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
    localparam int MEM_WORDS_DEF = 64;
    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, STORE_WR, RESP} state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: little-endian sub-word extraction for loads and byte/halfword merge for stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] bmask;
    logic [31:0] hmask;

    assign b     = 8'(word >> {lane, 3'b000});
    assign h     = lane[1] ? word[31:16] : word[15:0];
    assign bmask = 32'h0000_00FF << {lane, 3'b000};
    assign hmask = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;

    assign load_val = funct3 == F3_B  ? {{24{b[7]}}, b} :
                      funct3 == F3_BU ? {24'd0, b} :
                      funct3 == F3_H  ? {{16{h[15]}}, h} :
                      funct3 == F3_HU ? {16'd0, h} : word;

    // Replicated data under a lane mask keeps the merge shift-free on the data path
    assign store_word = funct3 == F3_B ? (word & ~bmask) | ({4{wdata[7:0]}} & bmask) :
                        funct3 == F3_H ? (word & ~hmask) | ({2{wdata[15:0]}} & hmask) : wdata;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW over a word-addressed memory,
// with read-modify-write for sub-word stores and early rejection of bad accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF,
    parameter int IDX_W     = $clog2(MEM_WORDS)
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam logic [29:0] LIMIT = 30'(MEM_WORDS);

    state_t           state;
    logic [IDX_W+1:0] addr_q;
    logic [2:0]       f3_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic             err_q;
    logic             illegal;
    logic             misaligned;
    logic             bad;
    logic [31:0]      load_val;
    logic [31:0]      store_word;

    assign illegal    = req_funct3[1:0] == 2'd3 || (req_store ? req_funct3[2] : req_funct3 == 3'd6);
    assign misaligned = (req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                        (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
    assign bad        = illegal || misaligned || req_addr[31:2] >= LIMIT;

    lsu_align u_align (
        .word       (mem_rdata),
        .lane       (addr_q[1:0]),
        .funct3     (f3_q),
        .wdata      (wdata_q),
        .load_val   (load_val),
        .store_word (store_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    addr_q  <= req_addr[IDX_W+1:0];
                    f3_q    <= req_funct3;
                    wdata_q <= req_wdata;
                    rdata_q <= '0;
                    err_q   <= bad;
                    state   <= bad ? RESP : !req_store ? LOAD : req_funct3 == F3_W ? STORE_WR : RMW_RD;
                end
                LOAD: begin
                    rdata_q <= load_val;
                    state   <= RESP;
                end
                // The merged word replaces the store data so STORE_WR is shared with SW
                RMW_RD: begin
                    wdata_q <= store_word;
                    state   <= STORE_WR;
                end
                STORE_WR: state <= RESP;
                default:  state <= IDLE;
            endcase
        end
    end

    assign req_ready  = state == IDLE;
    assign resp_valid = state == RESP;
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign mem_read   = state == LOAD || state == RMW_RD;
    assign mem_write  = state == STORE_WR;
    assign mem_addr   = (mem_read || mem_write) ? 32'(addr_q[IDX_W+1:2]) : '0;
    assign mem_wdata  = mem_write ? wdata_q : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed-vector bench with a behavioural word memory behind the unit.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [64];
    logic        preload = 1'b1;
    int          n_rd = 0;
    int          n_wr = 0;
    int          n_both = 0;
    logic [31:0] last_wa = 32'd0;
    logic [31:0] last_wd = 32'd0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[5:0]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'(i) * 32'h0101_0101;
            mem[10] <= 32'h8081_82F3;
        end else if (mem_write) begin
            mem[mem_addr[5:0]] <= mem_wdata;
        end
        if (mem_read) n_rd <= n_rd + 1;
        if (mem_write) begin
            n_wr    <= n_wr + 1;
            last_wa <= mem_addr;
            last_wd <= mem_wdata;
        end
        if (mem_read && mem_write) n_both <= n_both + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic access(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic err);
        logic got;
        wait_ready(tag);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        got = 1'b0;
        lat = 0;
        rd  = 32'd0;
        err = 1'b0;
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1'b1;
                lat = i;
                rd  = resp_rdata;
                err = resp_err;
            end
        end
        if (!got) check({tag, "_resp_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        check({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
    endtask

    task automatic run(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int exp_lat, input logic [31:0] exp_rd, input logic exp_err,
                       input int exp_nrd, input int exp_nwr);
        int lat, rd0, wr0;
        logic [31:0] rd;
        logic err;
        rd0 = n_rd;
        wr0 = n_wr;
        access(tag, st, f3, addr, wd, lat, rd, err);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_nread"}, 32'(n_rd - rd0), 32'(exp_nrd));
        check({tag, "_nwrite"}, 32'(n_wr - wr0), 32'(exp_nwr));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        preload = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mem_ctl", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        reset = 1'b1;

        run("lb_28",  1'b0, 3'd0, 32'h28, 32'd0, 2, 32'hFFFF_FFF3, 1'b0, 1, 0);
        run("lbu_29", 1'b0, 3'd4, 32'h29, 32'd0, 2, 32'h0000_0082, 1'b0, 1, 0);
        run("lh_2a",  1'b0, 3'd1, 32'h2A, 32'd0, 2, 32'hFFFF_8081, 1'b0, 1, 0);
        run("lhu_2a", 1'b0, 3'd5, 32'h2A, 32'd0, 2, 32'h0000_8081, 1'b0, 1, 0);

        run("sb_29", 1'b1, 3'd0, 32'h29, 32'h1234_5655, 3, 32'd0, 1'b0, 1, 1);
        check("sb_29_waddr", last_wa, 32'd10);
        check("sb_29_wdata", last_wd, 32'h8081_55F3);
        check("sb_29_mem", mem[10], 32'h8081_55F3);

        run("sw_50", 1'b1, 3'd2, 32'h50, 32'hDEAD_BEEF, 2, 32'd0, 1'b0, 0, 1);
        check("sw_50_waddr", last_wa, 32'd20);
        check("sw_50_wdata", last_wd, 32'hDEAD_BEEF);
        run("lw_50", 1'b0, 3'd2, 32'h50, 32'd0, 2, 32'hDEAD_BEEF, 1'b0, 1, 0);

        run("err_lw_2a",  1'b0, 3'd2, 32'h2A,  32'd0, 1, 32'd0, 1'b1, 0, 0);
        run("err_sh_2b",  1'b1, 3'd1, 32'h2B,  32'h1111_2222, 1, 32'd0, 1'b1, 0, 0);
        run("err_lw_100", 1'b0, 3'd2, 32'h100, 32'd0, 1, 32'd0, 1'b1, 0, 0);
        run("err_f3_3",   1'b0, 3'd3, 32'h28,  32'd0, 1, 32'd0, 1'b1, 0, 0);
        run("err_sbu",    1'b1, 3'd4, 32'h28,  32'd0, 1, 32'd0, 1'b1, 0, 0);

        begin : reset_mid
            int wr0;
            wr0 = n_wr;
            wait_ready("rst_sh");
            req_valid  = 1'b1;
            req_store  = 1'b1;
            req_funct3 = 3'd1;
            req_addr   = 32'h28;
            req_wdata  = 32'h0000_AAAA;
            @(posedge clk);
            #1 req_valid = 1'b0;
            @(negedge clk);
            check("rst_sh_in_rmw", 32'(mem_read), 32'd1);
            reset = 1'b0;
            #1;
            check("rst_sh_ready", 32'(req_ready), 32'd1);
            check("rst_sh_nowrite", 32'(mem_write), 32'd0);
            @(posedge clk);
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            check("rst_sh_ready2", 32'(req_ready), 32'd1);
            check("rst_sh_resp", 32'(resp_valid), 32'd0);
            check("rst_sh_nwrite", 32'(n_wr - wr0), 32'd0);
            check("rst_sh_mem", mem[10], 32'h8081_55F3);
        end

        begin : back_to_back
            wait_ready("b2b");
            req_valid  = 1'b1;
            req_store  = 1'b0;
            req_funct3 = 3'd2;
            req_addr   = 32'h28;
            @(posedge clk);
            #1;
            req_store  = 1'b1;
            req_addr   = 32'h2C;
            req_wdata  = 32'hCAFE_0001;
            @(negedge clk);
            check("b2b_busy_load", 32'(req_ready), 32'd0);
            @(negedge clk);
            check("b2b_busy_resp", 32'(req_ready), 32'd0);
            check("b2b_lw_valid", 32'(resp_valid), 32'd1);
            check("b2b_lw_rdata", resp_rdata, 32'h8081_55F3);
            check("b2b_no_early_wr", 32'(mem_write), 32'd0);
            @(negedge clk);
            check("b2b_idle_ready", 32'(req_ready), 32'd1);
            @(posedge clk);
            #1 req_valid = 1'b0;
            @(negedge clk);
            check("b2b_sw_busy", 32'(req_ready), 32'd0);
            check("b2b_sw_write", 32'(mem_write), 32'd1);
            check("b2b_sw_addr", mem_addr, 32'd11);
            @(negedge clk);
            check("b2b_sw_resp", 32'(resp_valid), 32'd1);
            check("b2b_sw_mem", mem[11], 32'hCAFE_0001);
        end

        check("never_both", 32'(n_both), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage (ALU address and control) and the word-organised data memory. It feeds that memory's MemRead, MemWrite, Mem_Addr and wr_data inputs and consumes its rd_data output.
- Implements RISC-V byte, halfword and word loads and stores on a 32-bit word-addressed memory with combinational read and synchronous write.
- Sub-word stores become a read-modify-write sequence.
- Misaligned, out-of-range and illegal-size accesses are flagged instead of being issued to memory.

Parameters:
- MEM_WORDS, 64, depth of the downstream memory in 32-bit words; word index must be < MEM_WORDS.
- IDX_W, 6, width of the word index (clog2 of MEM_WORDS).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  access request present.
- req_ready  output  1  unit idle and able to accept a request.
- req_store  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3 (size and unsigned flag).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data (low bits used for sub-word).
- resp_valid  output  1  one-cycle pulse: access complete.
- resp_err  output  1  valid with resp_valid: access rejected.
- resp_rdata  output  32  load result, valid with resp_valid.
- mem_read  output  1  to memory MemRead.
- mem_write  output  1  to memory MemWrite.
- mem_addr  output  32  to memory Mem_Addr, word index zero-extended.
- mem_wdata  output  32  to memory wr_data.
- mem_rdata  input  32  from memory rd_data.

Behaviour:
- States: IDLE, LOAD, RMW_RD, STORE_WR, RESP.
- req_ready = 1 only in IDLE. Accept on a rising edge with req_valid && req_ready; addr, funct3, store flag and wdata are captured.
- Word index = addr[IDX_W+1:2]. Byte lane = addr[1:0]. Little-endian.
- Legal loads: funct3 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. Legal stores: 0 SB, 1 SH, 2 SW. Any other funct3 is illegal.
- Error conditions, checked at accept:
  - illegal funct3;
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:2] >= MEM_WORDS.
- On error: IDLE -> RESP directly; no mem_read or mem_write; resp_err=1; resp_rdata=0.
- Load: IDLE -> LOAD. In LOAD, mem_read=1 and mem_addr=index. At the LOAD edge, mem_rdata is extracted and extended into resp_rdata, then -> RESP. Latency: resp_valid 2 cycles after accept.
- Extraction:
  - LB/LBU: byte at lane, sign-extended or zero-extended.
  - LH/LHU: halfword at addr[1], sign-extended or zero-extended.
- SW: IDLE -> STORE_WR, with mem_write=1 and mem_wdata=wdata. Then -> RESP (2 cycles).
- SB/SH: IDLE -> RMW_RD, with mem_read=1. At the edge, latch mem_rdata with the target byte or halfword replaced by wdata[7:0] or wdata[15:0]. Then STORE_WR writes the merged word, then RESP (3 cycles).
- RESP: resp_valid=1 for exactly one cycle, then -> IDLE. A new request may be accepted the cycle after RESP.
- mem_read and mem_write are never both 1. Each is asserted only in the states listed above. mem_addr and mem_wdata are 0 when neither is asserted.
- Reset (asserted low, any state): immediate return to IDLE; the in-flight access is abandoned with no write. All outputs are 0 except req_ready=1. Captured registers are cleared.
- req_valid while busy is ignored (no queueing); upstream holds it.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state enum;
  - MEM_WORDS default.
- One combinational sub-module, lsu_align:
  - inputs: word, lane, funct3, store data;
  - outputs: extended load value and merged store word.
- The FSM and the check logic stay in load_store_unit.

Test Plan:
- Word index 10 = 0x808182F3; LB addr 0x28 -> resp_rdata 0xFFFFFFF3. LBU 0x29 -> 0x00000082. LH 0x2A -> 0xFFFF8081. LHU 0x2A -> 0x00008081. Each gives resp_valid 2 cycles after accept, with exactly one mem_read cycle.
- SB addr 0x29, wdata 0x12345655 -> one RMW_RD read then one mem_write of 0x808155F3 to index 10. resp_valid 3 cycles after accept, resp_err 0.
- SW addr 0x50, wdata 0xDEADBEEF -> one mem_write of 0xDEADBEEF to index 20, no mem_read, resp 2 cycles after accept. A following LW 0x50 returns 0xDEADBEEF.
- LW 0x2A, SH 0x2B, LW 0x100 (index 64), and load with funct3 3 -> each gives resp_err=1 and resp_rdata=0 one cycle after accept. No mem_read or mem_write is ever asserted.
- SH addr 0x28 accepted; reset pulled low during RMW_RD -> no mem_write. After release, req_ready=1, resp_valid=0, and the word is unchanged.
- req_valid held high across back-to-back LW 0x28 and SW 0x2C -> second request accepted only in IDLE after the first RESP; req_ready=0 throughout the busy cycles.
